gate_sweep_controller: RTL

GATE_SWEEP_CONTROLLER -- requirements
Module: gate_sweep_controller

---
 rtl/gate_sweep_pkg.sv | 17 +
 rtl/gate_ref_model.sv | 22 ++
 rtl/gate_sweep_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller: FSM state encoding,
// vector-space size and the width of the expected gate output word.
package gate_sweep_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int EXP_W       = 3;
  localparam int STATE_W     = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [STATE_W-1:0] ST_CHECK  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

  // The error counter tops out at one mismatch per vector.
  localparam logic [4:0] ERR_SAT = 5'(NUM_VECTORS);

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model of the gate under test:
// e = a&b, f = c&d, g = a&b&c&d, where a is the MSB of the vector.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0] vec_i,
  output logic [EXP_W-1:0]  expected_o
);

  logic andAb;
  logic andCd;

  // Form the two pair products and the four-input product from them.
  always_comb begin
    andAb      = vec_i[NUM_IN-1] & vec_i[NUM_IN-2];
    andCd      = vec_i[1] & vec_i[0];
    expected_o = {andAb, andCd, andAb & andCd};
  end

endmodule

// File: rtl/gate_sweep_controller.sv
// Exhaustive gate tester: walks gate_in through every input vector in
// ascending order, waits SETTLE_CYCLES after each step, compares the captured
// gate outputs with the reference model and records the mismatch count and
// the first failing vector.
module gate_sweep_controller
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_IN        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_IN-1:0] gate_in,
  input  logic [EXP_W-1:0]  gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic              fail_valid,
  output logic [NUM_IN-1:0] first_fail_vec
);

  // With zero settle cycles the SETTLE state is skipped entirely so that
  // every vector costs exactly one CHECK cycle.
  localparam bit                SKIP_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [3:0]        SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [NUM_IN-1:0] LAST_VEC    = '1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [NUM_IN-1:0]  gate_in_q, gate_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [4:0]         err_count_q, err_count_d;
  logic               fail_valid_q, fail_valid_d;
  logic [NUM_IN-1:0]  first_fail_q, first_fail_d;
  logic [3:0]         settle_cnt_q, settle_cnt_d;

  logic [EXP_W-1:0]   expected;
  logic               mismatch;

  gate_ref_model #(
    .NUM_IN(NUM_IN)
  ) u_ref (
    .vec_i     (gate_in_q),
    .expected_o(expected)
  );

  assign mismatch = (gate_out != expected);

  // Next-state logic: sequencing of the sweep, vector stepping and result capture.
  always_comb begin
    state_d      = state_q;
    gate_in_d    = gate_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    settle_cnt_d = settle_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          err_count_d  = 5'd0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          gate_in_d    = '0;
          busy_d       = 1'b1;
          settle_cnt_d = 4'd0;
          state_d      = SKIP_SETTLE ? ST_CHECK : ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          pass_d       = 1'b0;
          settle_cnt_d = 4'd0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = 4'd0;
          state_d      = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end

      ST_CHECK: begin
        if (abort) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          pass_d       = 1'b0;
          settle_cnt_d = 4'd0;
        end else begin
          if (mismatch) begin
            if (err_count_q < ERR_SAT) begin
              err_count_d = err_count_q + 5'd1;
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              first_fail_d = gate_in_q;
            end
          end
          if (gate_in_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            gate_in_d = gate_in_q + 1'b1;
            state_d   = SKIP_SETTLE ? ST_CHECK : ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == 5'd0);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any sweep in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gate_in_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 5'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      settle_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      gate_in_q    <= gate_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign gate_in        = gate_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule
